// File: rtl/axi4l_master_port_if.sv
// AXI4-Lite bus bundle between a single master and a single slave.
// The master modport drives addresses, data and the valids/readies it owns.
interface axi4l_master_port_if #(
    parameter int AW = 32
);
    logic [AW-1:0] m_axi_awaddr;
    logic [2:0]    m_axi_awprot;
    logic          m_axi_awvalid;
    logic          m_axi_awready;

    logic [31:0]   m_axi_wdata;
    logic [3:0]    m_axi_wstrb;
    logic          m_axi_wvalid;
    logic          m_axi_wready;

    logic [1:0]    m_axi_bresp;
    logic          m_axi_bvalid;
    logic          m_axi_bready;

    logic [AW-1:0] m_axi_araddr;
    logic [2:0]    m_axi_arprot;
    logic          m_axi_arvalid;
    logic          m_axi_arready;

    logic [31:0]   m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rvalid;
    logic          m_axi_rready;

    modport master (
        output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface

// File: rtl/axi4l_master_port.sv
// Single-outstanding AXI4-Lite master: turns one cmd handshake into one AXI
// write or read and returns the result on a held rsp handshake.
module axi4l_master_port #(
    parameter int         AW   = 32,
    parameter logic [2:0] PROT = 3'b000
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_wr,
    input  logic [AW-1:0] cmd_addr,
    input  logic [31:0]   cmd_wdata,
    input  logic [3:0]    cmd_wstrb,

    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_wr,
    output logic [31:0]   rsp_rdata,
    output logic [1:0]    rsp_resp,

    axi4l_master_port_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        WADDR_DATA,
        WRESP,
        RADDR,
        RDATA,
        RSP
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic          bready_q, bready_d;
    logic          arvalid_q, arvalid_d;
    logic          rready_q, rready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_wr_q, rsp_wr_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]    rsp_resp_q, rsp_resp_d;

    // NOTE: state updates use non-blocking assignments; reset is synchronous, so it is just the first branch of the clocked block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_wr_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_wr_q    <= rsp_wr_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    // NOTE: every variable gets its hold value first, so no path through the case can infer a latch.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_wr_d    = rsp_wr_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (cmd_wr) begin
                        state_d   = WADDR_DATA;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = RADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WADDR_DATA: begin
                // AW and W complete independently, in either order or together.
                if (awvalid_q && bus.m_axi_awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && bus.m_axi_wready) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d  = WRESP;
                    bready_d = 1'b1;
                end
            end
            WRESP: begin
                if (bus.m_axi_bvalid) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = bus.m_axi_bresp;
                    rsp_rdata_d = '0;
                    rsp_wr_d    = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RADDR: begin
                if (bus.m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RDATA;
                end
            end
            RDATA: begin
                if (bus.m_axi_rvalid) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = bus.m_axi_rdata;
                    rsp_resp_d  = bus.m_axi_rresp;
                    rsp_wr_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready = (state_q == IDLE);

    assign bus.m_axi_awaddr  = addr_q;
    assign bus.m_axi_awprot  = PROT;
    assign bus.m_axi_awvalid = awvalid_q;
    assign bus.m_axi_wdata   = wdata_q;
    assign bus.m_axi_wstrb   = wstrb_q;
    assign bus.m_axi_wvalid  = wvalid_q;
    assign bus.m_axi_bready  = bready_q;
    assign bus.m_axi_araddr  = addr_q;
    assign bus.m_axi_arprot  = PROT;
    assign bus.m_axi_arvalid = arvalid_q;
    assign bus.m_axi_rready  = rready_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_wr    = rsp_wr_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;

endmodule

// File: tb/tb_axi4l_master_port.sv
// Bench for axi4l_master_port: behavioural AXI4-Lite slave with per-channel
// stall knobs, protocol monitor, and a response scoreboard.
module tb_axi4l_master_port;
    localparam int AW = 32;

    typedef struct packed {
        logic        wr;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } rsp_t;

    logic          clk = 1'b1;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_wr;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_resp;

    axi4l_master_port_if #(.AW(AW)) bus ();

    axi4l_master_port #(.AW(AW), .PROT(3'b000)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_wr    (rsp_wr),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    rsp_t sb[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];

    // Slave behaviour knobs: cycles of stall before each ready, response codes.
    int         aw_lat = 0, w_lat = 0, ar_lat = 0;
    logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;

    int aw_hs_cyc, w_hs_cyc, ar_hs_cyc, bready_rise_cyc, rsp_rise_cyc, rsp_hs_cyc;
    int rsp_rise_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    logic        s_got_aw, s_got_w, s_got_ar, b_fire, r_fire;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    int          aw_cnt, w_cnt, ar_cnt;
    logic        m_aw, m_w;
    logic        p_rst, p_awvalid, p_awready, p_wvalid, p_wready, p_arvalid, p_arready;
    logic        p_bready, p_rsp_valid, p_rsp_ready, p_rsp_wr;
    logic [31:0] p_awaddr, p_wdata, p_araddr, p_rsp_rdata;
    logic [3:0]  p_wstrb;
    logic [1:0]  p_rsp_resp;
    rsp_t        mon_exp;

    // Slave and monitor run mid-cycle, so everything they read is settled.
    always @(negedge clk) begin
        if (rst) begin
            bus.m_axi_awready = 1'b0;
            bus.m_axi_wready  = 1'b0;
            bus.m_axi_arready = 1'b0;
            bus.m_axi_bvalid  = 1'b0;
            bus.m_axi_bresp   = 2'b00;
            bus.m_axi_rvalid  = 1'b0;
            bus.m_axi_rresp   = 2'b00;
            bus.m_axi_rdata   = 32'h0;
            s_got_aw = 1'b0; s_got_w = 1'b0; s_got_ar = 1'b0;
            b_fire = 1'b0; r_fire = 1'b0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
            m_aw = 1'b0; m_w = 1'b0;
            p_rst = 1'b1; p_awvalid = 1'b0; p_awready = 1'b0; p_wvalid = 1'b0;
            p_wready = 1'b0; p_arvalid = 1'b0; p_arready = 1'b0; p_bready = 1'b0;
            p_rsp_valid = 1'b0; p_rsp_ready = 1'b0;
        end else begin
            if (!p_rst) begin
                if (p_awvalid) begin
                    if (p_awready) check("aw_drop", bus.m_axi_awvalid, 1'b0);
                    else begin
                        check("aw_hold", bus.m_axi_awvalid, 1'b1);
                        check("awaddr_stable", bus.m_axi_awaddr, p_awaddr);
                    end
                end
                if (p_wvalid) begin
                    if (p_wready) check("w_drop", bus.m_axi_wvalid, 1'b0);
                    else begin
                        check("w_hold", bus.m_axi_wvalid, 1'b1);
                        check("w_payload_stable", {bus.m_axi_wstrb, bus.m_axi_wdata}, {p_wstrb, p_wdata});
                    end
                end
                if (p_arvalid) begin
                    if (p_arready) check("ar_drop", bus.m_axi_arvalid, 1'b0);
                    else begin
                        check("ar_hold", bus.m_axi_arvalid, 1'b1);
                        check("araddr_stable", bus.m_axi_araddr, p_araddr);
                    end
                end
                if (p_rsp_valid && !p_rsp_ready)
                    check("rsp_hold", {rsp_valid, rsp_wr, rsp_resp, rsp_rdata},
                          {1'b1, p_rsp_wr, p_rsp_resp, p_rsp_rdata});
            end
            if (bus.m_axi_bready && !p_bready) begin
                check("bready_after_aw_w", {m_aw, m_w}, 2'b11);
                bready_rise_cyc = cyc;
                m_aw = 1'b0;
                m_w  = 1'b0;
            end
            if (rsp_valid && !p_rsp_valid) begin
                rsp_rise_cyc = cyc;
                rsp_rise_cnt++;
            end
            if (rsp_valid && rsp_ready) begin
                rsp_hs_cyc = cyc;
                check("rsp_expected", sb.size() > 0, 1'b1);
                if (sb.size() > 0) begin
                    mon_exp = sb.pop_front();
                    check("rsp_wr", rsp_wr, mon_exp.wr);
                    check("rsp_rdata", rsp_rdata, mon_exp.rdata);
                    check("rsp_resp", rsp_resp, mon_exp.resp);
                end
            end

            // B and R channels act on handshakes decided on earlier cycles.
            if (b_fire) begin bus.m_axi_bvalid = 1'b0; b_fire = 1'b0; end
            if (s_got_aw && s_got_w) begin
                slv_mem[s_awaddr] = merge(slv_mem.exists(s_awaddr) ? slv_mem[s_awaddr] : 32'h0,
                                          s_wdata, s_wstrb);
                s_got_aw = 1'b0;
                s_got_w  = 1'b0;
                bus.m_axi_bvalid = 1'b1;
                bus.m_axi_bresp  = bresp_cfg;
            end
            if (bus.m_axi_bvalid && bus.m_axi_bready) b_fire = 1'b1;

            if (r_fire) begin bus.m_axi_rvalid = 1'b0; r_fire = 1'b0; end
            if (s_got_ar) begin
                bus.m_axi_rvalid = 1'b1;
                bus.m_axi_rdata  = slv_mem.exists(s_araddr) ? slv_mem[s_araddr] : 32'h0;
                bus.m_axi_rresp  = rresp_cfg;
                s_got_ar = 1'b0;
            end
            if (bus.m_axi_rvalid && bus.m_axi_rready) r_fire = 1'b1;

            if (bus.m_axi_awvalid) begin
                bus.m_axi_awready = (aw_cnt >= aw_lat) && !s_got_aw;
                aw_cnt++;
                if (bus.m_axi_awready) begin
                    s_got_aw = 1'b1; s_awaddr = bus.m_axi_awaddr; m_aw = 1'b1; aw_hs_cyc = cyc;
                end
            end else begin
                bus.m_axi_awready = 1'b0; aw_cnt = 0;
            end
            if (bus.m_axi_wvalid) begin
                bus.m_axi_wready = (w_cnt >= w_lat) && !s_got_w;
                w_cnt++;
                if (bus.m_axi_wready) begin
                    s_got_w = 1'b1; s_wdata = bus.m_axi_wdata; s_wstrb = bus.m_axi_wstrb;
                    m_w = 1'b1; w_hs_cyc = cyc;
                end
            end else begin
                bus.m_axi_wready = 1'b0; w_cnt = 0;
            end
            if (bus.m_axi_arvalid) begin
                bus.m_axi_arready = (ar_cnt >= ar_lat) && !s_got_ar;
                ar_cnt++;
                if (bus.m_axi_arready) begin
                    s_got_ar = 1'b1; s_araddr = bus.m_axi_araddr; ar_hs_cyc = cyc;
                end
            end else begin
                bus.m_axi_arready = 1'b0; ar_cnt = 0;
            end

            p_rst = 1'b0;
            p_awvalid = bus.m_axi_awvalid; p_awready = bus.m_axi_awready; p_awaddr = bus.m_axi_awaddr;
            p_wvalid = bus.m_axi_wvalid; p_wready = bus.m_axi_wready;
            p_wdata = bus.m_axi_wdata; p_wstrb = bus.m_axi_wstrb;
            p_arvalid = bus.m_axi_arvalid; p_arready = bus.m_axi_arready; p_araddr = bus.m_axi_araddr;
            p_bready = bus.m_axi_bready;
            p_rsp_valid = rsp_valid; p_rsp_ready = rsp_ready; p_rsp_wr = rsp_wr;
            p_rsp_rdata = rsp_rdata; p_rsp_resp = rsp_resp;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output int acc);
        rsp_t e;
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        if (wr) begin
            ref_mem[a] = merge(ref_mem.exists(a) ? ref_mem[a] : 32'h0, d, s);
            e = '{wr: 1'b1, rdata: 32'h0, resp: bresp_cfg};
        end else begin
            e = '{wr: 1'b0, rdata: (ref_mem.exists(a) ? ref_mem[a] : 32'h0), resp: rresp_cfg};
        end
        sb.push_back(e);
        acc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin acc = cyc; break; end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("cmd_accepted", acc >= 0, 1'b1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && cmd_ready) break;
        end
        check("drain", (sb.size() == 0) && cmd_ready, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, cnt0, mx, seen;
        int awl[3] = '{2, 0, 1};
        int wl[3]  = '{0, 2, 1};
        logic [1:0] brs[3] = '{2'b00, 2'b00, 2'b11};
        logic [31:0] d;

        rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_valids", {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid,
                             bus.m_axi_bready, bus.m_axi_rready, rsp_valid}, 6'b0);
        check("rst_rsp", {rsp_wr, rsp_resp, rsp_rdata}, 35'h0);
        check("rst_regs", {bus.m_axi_awaddr, bus.m_axi_wdata, bus.m_axi_wstrb}, 68'h0);
        @(posedge clk); #1;

        // Zero-wait write
        send_cmd(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, c0);
        wait_idle();
        check("t1_aw_hs", aw_hs_cyc, c0 + 1);
        check("t1_w_hs", w_hs_cyc, c0 + 1);
        check("t1_bready", bready_rise_cyc, c0 + 2);
        check("t1_rsp_valid", rsp_rise_cyc, c0 + 3);

        // Read with AR stalled 3 cycles, SLVERR passed through
        slv_mem[32'h8] = 32'h1234_5678;
        ref_mem[32'h8] = 32'h1234_5678;
        ar_lat = 3; rresp_cfg = 2'b10;
        send_cmd(1'b0, 32'h0000_0008, 32'h0, 4'h0, c0);
        wait_idle();
        check("t2_ar_hs", ar_hs_cyc, c0 + 4);
        check("t2_rsp_valid", rsp_rise_cyc, c0 + 6);
        ar_lat = 0; rresp_cfg = 2'b00;

        // W before AW, AW before W, both together (last one with DECERR)
        for (int i = 0; i < 3; i++) begin
            aw_lat = awl[i]; w_lat = wl[i]; bresp_cfg = brs[i];
            mx = (awl[i] > wl[i]) ? awl[i] : wl[i];
            cnt0 = rsp_rise_cnt;
            send_cmd(1'b1, 32'h10 + 4 * i, 32'hA000_0000 + i, 4'b0101 << i[1:0], c0);
            wait_idle();
            check("t3_aw_hs", aw_hs_cyc, c0 + 1 + awl[i]);
            check("t3_w_hs", w_hs_cyc, c0 + 1 + wl[i]);
            check("t3_bready", bready_rise_cyc, c0 + 2 + mx);
            check("t3_rsp_valid", rsp_rise_cyc, c0 + 3 + mx);
            check("t3_one_rsp", rsp_rise_cnt, cnt0 + 1);
        end
        aw_lat = 0; w_lat = 0; bresp_cfg = 2'b00;
        send_cmd(1'b0, 32'h14, 32'h0, 4'h0, c0);
        wait_idle();

        // Response back-pressure with a read queued behind it
        rsp_ready = 1'b0;
        send_cmd(1'b1, 32'h20, 32'hA5A5_5A5A, 4'hF, c0);
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h20;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid) begin seen = 1; break; end
        end
        check("t4_rsp_seen", seen, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_cmd_blocked", {cmd_ready, bus.m_axi_arvalid, rsp_valid}, 3'b001);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        send_cmd(1'b0, 32'h20, 32'h0, 4'h0, c1);
        check("t4_read_accept", c1, rsp_hs_cyc + 1);
        wait_idle();
        check("t4_ar_after_rsp", ar_hs_cyc > c1, 1'b1);

        // Back-to-back alternating write/read, 4-cycle throughput
        c1 = -1;
        for (int i = 0; i < 8; i++) begin
            d = $urandom();
            send_cmd(i % 2 == 0, 32'h100 + 4 * (i / 2), d, 4'hF, c0);
            if (i > 0) check("t5_throughput", c0 - c1, 4);
            c1 = c0;
        end
        wait_idle();

        // Reset in the middle of a stalled write
        aw_lat = 10; w_lat = 10;
        cnt0 = rsp_rise_cnt;
        send_cmd(1'b1, 32'h200, 32'h55, 4'hF, c0);
        @(negedge clk);
        check("t6_awvalid_pre", bus.m_axi_awvalid, 1'b1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("t6_valids_cleared", {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid,
                                    bus.m_axi_bready, bus.m_axi_rready, rsp_valid}, 6'b0);
        check("t6_cmd_ready", cmd_ready, 1'b1);
        void'(sb.pop_back());
        aw_lat = 0; w_lat = 0;
        repeat (10) @(negedge clk);
        check("t6_no_rsp", rsp_rise_cnt, cnt0);
        @(posedge clk); #1;
        send_cmd(1'b1, 32'h200, 32'h600D_CAFE, 4'hF, c0);
        send_cmd(1'b0, 32'h200, 32'h0, 4'h0, c0);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
